// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and controller states.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/sum streams and control of the nibble-serial adder, grouped as one bundle.
interface nibble_serial_adder_if;
    import nsa_pkg::*;

    logic                START;
    logic                CIN;
    logic                IN_VALID;
    logic                IN_READY;
    logic [NIBBLE_W-1:0] A;
    logic [NIBBLE_W-1:0] B;
    logic                OUT_VALID;
    logic                OUT_READY;
    logic [NIBBLE_W-1:0] SUM;
    logic                OUT_LAST;
    logic                CARRY;
    logic                OVERFLOW;
    logic                BUSY;

    modport master (
        output START, CIN, IN_VALID, A, B, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, OUT_LAST, CARRY, OVERFLOW, BUSY
    );

    modport slave (
        input  START, CIN, IN_VALID, A, B, OUT_READY,
        output IN_READY, OUT_VALID, SUM, OUT_LAST, CARRY, OVERFLOW, BUSY
    );

endinterface

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-add slice; exposes the carry into the MSB for overflow detection.
module nibble_add_slice
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                c3
);

    logic c1, c2;

    always_comb begin
        sum[0] = a[0] ^ b[0] ^ cin;
        c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
        sum[1] = a[1] ^ b[1] ^ c1;
        c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
        sum[2] = a[2] ^ b[2] ^ c2;
        c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
        sum[3] = a[3] ^ b[3] ^ c3;
        cout   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder: one nibble per beat through a single slice, carry chained in a register,
// with a one-entry output register on the sum stream.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    nibble_serial_adder_if.slave  bus
);

    localparam int CNT_W = $clog2(NIBBLES) + 1;

    state_e              state_q, state_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NIBBLE_W-1:0] sum_q, sum_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                carry_flag_q, carry_flag_d;
    logic                ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic                slice_c3;
    logic                in_ready;
    logic                last_beat;

    nibble_add_slice u_slice (
        .a    (bus.A),
        .b    (bus.B),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    // Accept a new beat whenever the output register is empty or is being drained this cycle.
    assign in_ready  = (state_q == RUN) && (!out_valid_q || bus.OUT_READY);
    assign last_beat = (cnt_q == CNT_W'(NIBBLES - 1));

    always_comb begin
        state_d      = state_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        carry_flag_d = carry_flag_q;
        ovf_d        = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    carry_d = bus.CIN;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_valid_q && bus.OUT_READY) out_valid_d = 1'b0;
                if (bus.IN_VALID && in_ready) begin
                    sum_d       = slice_sum;
                    out_valid_d = 1'b1;
                    carry_d     = slice_cout;
                    cnt_d       = cnt_q + CNT_W'(1);
                    out_last_d  = last_beat;
                    if (last_beat) begin
                        carry_flag_d = slice_cout;
                        ovf_d        = slice_c3 ^ slice_cout;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid_q && bus.OUT_READY) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            sum_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            carry_flag_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            carry_flag_q <= carry_flag_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.SUM       = sum_q;
    assign bus.OUT_LAST  = out_last_q;
    assign bus.CARRY     = carry_flag_q;
    assign bus.OVERFLOW  = ovf_q;
    assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: expected beats queued at drive time, popped on output handshakes.
module tb_nibble_serial_adder;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [3:0] sum;
        logic       last;
        logic       carry;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   lat_first = -1;
    int   lat_last  = -1;
    exp_t sb[$];

    nibble_serial_adder_if bus ();

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] s;
        logic       ovf;
        exp_t       e;
        s   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        for (int i = 0; i < NIB; i++) begin
            e.sum   = s[4*i +: 4];
            e.last  = (i == NIB - 1);
            e.carry = s[W];
            e.ovf   = ovf;
            sb.push_back(e);
        end
    endfunction

    // Scoreboard consumer and latency tracker.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (bus.IN_VALID && bus.IN_READY && lat_first < 0) lat_first = cyc;
            if (bus.OUT_VALID && bus.OUT_LAST && lat_last < 0) lat_last = cyc;
            if (bus.OUT_VALID && bus.OUT_READY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", 32'(bus.SUM), 32'(e.sum));
                    chk("last", 32'(bus.OUT_LAST), 32'(e.last));
                    if (e.last) begin
                        chk("carry", 32'(bus.CARRY), 32'(e.carry));
                        chk("overflow", 32'(bus.OVERFLOW), 32'(e.ovf));
                    end
                end
            end
        end
    end

    task automatic pulse_start(input logic cin);
        bus.START = 1'b1;
        bus.CIN   = cin;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        bus.CIN   = 1'b0;
    endtask

    task automatic feed(input logic [3:0] a, input logic [3:0] b);
        int   n   = 0;
        logic acc = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.A = a;
        bus.B = b;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.IN_READY;
            @(posedge clk);
            #1;
            n++;
        end
        bus.IN_VALID = 1'b0;
        chk("feed_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.BUSY && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(bus.BUSY), 32'd0);
        @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        push_exp(a, b, cin);
        pulse_start(cin);
        for (int i = 0; i < NIB; i++) feed(a[4*i +: 4], b[4*i +: 4]);
        wait_idle();
    endtask

    task automatic backpressure();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.OUT_VALID && n < 50);
        chk("bp_first_valid", 32'(bus.OUT_VALID), 32'd1);
        bus.OUT_READY = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.IN_READY), 32'd0);
            chk("bp_sum_hold", 32'(bus.SUM), 32'd1);
            chk("bp_valid_hold", 32'(bus.OUT_VALID), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.OUT_READY = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.IN_READY), 32'd0);
        chk({tag, "_out_valid"}, 32'(bus.OUT_VALID), 32'd0);
        chk({tag, "_out_last"}, 32'(bus.OUT_LAST), 32'd0);
        chk({tag, "_carry"}, 32'(bus.CARRY), 32'd0);
        chk({tag, "_overflow"}, 32'(bus.OVERFLOW), 32'd0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        chk({tag, "_sum"}, 32'(bus.SUM), 32'd0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst_n         = 1'b0;
        bus.START     = 1'b0;
        bus.CIN       = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.OUT_READY = 1'b1;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add plus latency from first accept to last output.
        lat_first = -1;
        lat_last  = -1;
        do_op(16'h1234, 16'h0FCD, 1'b0);
        chk("latency_cycles", 32'(lat_last - lat_first + 1), 32'(NIB + 1));

        do_op(16'hFFFF, 16'h0000, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0);

        fork
            do_op(16'h1234, 16'h0FCD, 1'b0);
            backpressure();
        join

        // START during RUN and DONE is ignored; START right after the final handshake is taken.
        a = 16'h1234;
        b = 16'h0FCD;
        push_exp(a, b, 1'b0);
        pulse_start(1'b0);
        feed(a[3:0], b[3:0]);
        bus.START = 1'b1;
        bus.CIN   = 1'b1;
        feed(a[7:4], b[7:4]);
        bus.START = 1'b0;
        bus.CIN   = 1'b0;
        chk("busy_in_run", 32'(bus.BUSY), 32'd1);
        feed(a[11:8], b[11:8]);
        feed(a[15:12], b[15:12]);
        bus.OUT_READY = 1'b0;
        bus.START     = 1'b1;
        bus.CIN       = 1'b1;
        @(negedge clk);
        chk("busy_in_done", 32'(bus.BUSY), 32'd1);
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        bus.CIN   = 1'b0;
        chk("busy_after_done_start", 32'(bus.BUSY), 32'd1);
        chk("done_held_valid", 32'(bus.OUT_VALID), 32'd1);
        bus.OUT_READY = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_handshake", 32'(bus.BUSY), 32'd0);
        a = 16'h7FFF;
        b = 16'h0001;
        push_exp(a, b, 1'b0);
        pulse_start(1'b0);
        chk("restart_accepted", 32'(bus.BUSY), 32'd1);
        for (int i = 0; i < NIB; i++) feed(a[4*i +: 4], b[4*i +: 4]);
        wait_idle();

        // Asynchronous reset after two accepted beats.
        a = 16'h1234;
        b = 16'h0FCD;
        push_exp(a, b, 1'b0);
        pulse_start(1'b0);
        feed(a[3:0], b[3:0]);
        feed(a[7:4], b[7:4]);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(bus.OUT_VALID), 32'd0);
            chk("post_rst_idle", 32'(bus.BUSY), 32'd0);
        end
        @(posedge clk);
        #1;
        do_op(16'h0001, 16'h0001, 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
